rv_rr_packet_arbiter: RTL and testbench

- Shares one ready/valid output channel between N_IN ready/valid requester channels using round-robin arbitration.
- A grant is locked for a whole packet: from the first beat offered on the output until the beat carrying last is accepted.
- Sits in the NoC router/NI datapath in front of a shared link or buffer. Downstream of this block, the output channel obeys the hold-data / hold-valid-until-ready rule.
- Zero-latency combinational datapath; only the arbitration state is registered.

---
 rtl/rv_rr_packet_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_rv_rr_packet_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_rr_packet_arbiter.sv
// rv_rr_packet_arbiter: shares one ready/valid output between N_IN requesters.
// Arbitration is round-robin, and a grant stays locked until the last beat of a packet is accepted.
// The datapath is combinational (zero latency); only the arbitration state is registered.
// Optional macro RV_RR_ARB_ASSERT_EN compiles in a simulation-only SVA checker.

`ifdef RV_RR_ARB_ASSERT_EN
module rv_rr_packet_arbiter_sva #(
   parameter int N_IN       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int PTR_W      = $clog2(N_IN)
) (
   input logic                  clk,
   input logic                  rst,
   input logic [N_IN-1:0]       in_valid,
   input logic [N_IN-1:0]       in_ready,
   input logic [DATA_WIDTH-1:0] out_data,
   input logic                  out_last,
   input logic                  out_valid,
   input logic                  out_ready,
   input logic [PTR_W-1:0]      grant_idx,
   input logic                  locked
);
   int unsigned wait_cnt_q [N_IN];

   a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      out_valid && !out_ready |=> $stable(out_data) && $stable(out_last) && out_valid)
      else $warning("arbiter: offered beat changed under backpressure");

   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready))
      else $warning("arbiter: more than one in_ready high");

   // Count packet completions seen while a channel waits with valid held.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_IN; i++) begin
         if (rst || !in_valid[i] || in_ready[i]) begin
            wait_cnt_q[i] <= 0;
         end else if (out_valid && out_ready && out_last) begin
            wait_cnt_q[i] <= wait_cnt_q[i] + 1;
         end else begin
            wait_cnt_q[i] <= wait_cnt_q[i];
         end
      end
   end

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
      a_lock_excl: assert property (@(posedge clk) disable iff (rst)
         locked && (grant_idx != PTR_W'(gi)) |-> !in_ready[gi])
         else $warning("arbiter: channel %0d ready while another holds the lock", gi);
      a_no_starve: assert property (@(posedge clk) disable iff (rst) wait_cnt_q[gi] <= N_IN)
         else $warning("arbiter: channel %0d starved", gi);
   end
endmodule
`endif

module rv_rr_packet_arbiter #(
   parameter int N_IN       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int PTR_W      = $clog2(N_IN)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_IN*DATA_WIDTH-1:0]   in_data,
   input  logic [N_IN-1:0]              in_last,
   input  logic [N_IN-1:0]              in_valid,
   output logic [N_IN-1:0]              in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PTR_W-1:0]             grant_idx,
   output logic                         locked
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] prio_ptr_q, prio_ptr_d;
   logic [PTR_W-1:0] grant_q, grant_d;
   logic             pick_valid_s;
   logic [PTR_W-1:0] pick_idx_s;
   logic [PTR_W:0]   scan_s;
   logic [PTR_W-1:0] g_s;
   logic             sel_valid_s;
   logic             sel_last_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(N_IN - 1)) begin
         r = {PTR_W{1'b0}};
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   // Round-robin scan from prio_ptr; descending offsets so the nearest valid channel wins last.
   always_comb begin
      pick_valid_s = 1'b0;
      pick_idx_s   = prio_ptr_q;
      scan_s       = {(PTR_W+1){1'b0}};
      for (int k = N_IN - 1; k >= 0; k--) begin
         scan_s = {1'b0, prio_ptr_q} + (PTR_W+1)'(k);
         scan_s = (scan_s >= (PTR_W+1)'(N_IN)) ? scan_s - (PTR_W+1)'(N_IN) : scan_s;
         pick_idx_s   = in_valid[scan_s[PTR_W-1:0]] ? scan_s[PTR_W-1:0] : pick_idx_s;
         pick_valid_s = pick_valid_s | in_valid[scan_s[PTR_W-1:0]];
      end
   end

   // Output mux: a held lock overrides the fresh pick; reset silences the handshake.
   always_comb begin
      g_s         = (state_q == ST_LOCKED) ? grant_q : pick_idx_s;
      sel_valid_s = in_valid[g_s];
      sel_last_s  = in_last[g_s];
      out_data    = in_data[int'(g_s) * DATA_WIDTH +: DATA_WIDTH];
      out_last    = sel_last_s;
      in_ready    = {N_IN{1'b0}};
      if (rst) begin
         out_valid = 1'b0;
         grant_idx = {PTR_W{1'b0}};
         locked    = 1'b0;
      end else begin
         out_valid     = sel_valid_s;
         in_ready[g_s] = out_ready;
         grant_idx     = g_s;
         locked        = (state_q == ST_LOCKED);
      end
   end

   // Next-state logic: lock on any offered beat that does not complete a packet.
   always_comb begin
      state_d    = state_q;
      prio_ptr_d = prio_ptr_q;
      grant_d    = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid_s && out_ready && sel_last_s) begin
               prio_ptr_d = next_ptr(pick_idx_s);
            end else if (pick_valid_s) begin
               state_d = ST_LOCKED;
               grant_d = pick_idx_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (sel_valid_s && out_ready && sel_last_s) begin
               state_d    = ST_IDLE;
               prio_ptr_d = next_ptr(grant_q);
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            prio_ptr_d = {PTR_W{1'b0}};
            grant_d    = {PTR_W{1'b0}};
         end
      endcase
   end

   // Arbitration state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prio_ptr_q <= {PTR_W{1'b0}};
         grant_q    <= {PTR_W{1'b0}};
      end else begin
         state_q    <= state_d;
         prio_ptr_q <= prio_ptr_d;
         grant_q    <= grant_d;
      end
   end

`ifdef RV_RR_ARB_ASSERT_EN
   rv_rr_packet_arbiter_sva #(
      .N_IN       (N_IN),
      .DATA_WIDTH (DATA_WIDTH),
      .PTR_W      (PTR_W)
   ) u_sva (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_idx (grant_idx),
      .locked    (locked)
   );
`endif

endmodule

// File: tb/tb_rv_rr_packet_arbiter.sv
// Self-checking bench for rv_rr_packet_arbiter: directed scenarios followed by random
// traffic, all compared against a packet-level reference model (owner + priority pointer).

module tb_rv_rr_packet_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int PW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;
   logic [PW-1:0]   grant_idx;
   logic            locked;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model: channel owning the current packet (-1 = none) and next-priority channel.
   int   m_ptr   = 0;
   int   m_owner = -1;
   int   m_g     = 0;
   logic m_ev    = 1'b0;

   always #5 clk = ~clk;

   rv_rr_packet_arbiter #(.N_IN(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_idx (grant_idx),
      .locked    (locked)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int ch, input logic [DW-1:0] v);
      in_data[ch*DW +: DW] = v;
   endtask

   // Compare every DUT output with what the model says should be on the wires now.
   task automatic model_check();
      logic         found;
      int           c;
      logic [N-1:0] er;
      found = 1'b0;
      if (m_owner >= 0) begin
         m_g = m_owner;
      end else begin
         m_g = m_ptr;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && in_valid[c]) begin
               m_g   = c;
               found = 1'b1;
            end
         end
      end
      m_ev = in_valid[m_g];
      if (rst) begin
         chk("rst_in_ready",  64'(in_ready),  64'(0));
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_locked",    64'(locked),    64'(0));
         chk("rst_grant_idx", 64'(grant_idx), 64'(0));
      end else begin
         er       = '0;
         er[m_g]  = out_ready;
         chk("in_ready",  64'(in_ready),  64'(er));
         chk("out_valid", 64'(out_valid), 64'(m_ev));
         chk("locked",    64'(locked),    64'(m_owner >= 0));
         chk("grant_idx", 64'(grant_idx), 64'(m_g));
         if (m_ev) begin
            chk("out_data", 64'(out_data), 64'(in_data[m_g*DW +: DW]));
            chk("out_last", 64'(out_last), 64'(in_last[m_g]));
         end
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_update();
      if (rst) begin
         m_ptr   = 0;
         m_owner = -1;
      end else if (m_ev) begin
         if (out_ready && in_last[m_g]) begin
            m_owner = -1;
            m_ptr   = (m_g + 1) % N;
         end else begin
            m_owner = m_g;
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'hF;
      in_last   = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + 32'(i));

      // Reset held with every requester valid.
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("reset_ready", 64'(in_ready),  64'(4'b0000));
         chk("reset_valid", 64'(out_valid), 64'(0));
         tick();
      end
      rst = 1'b0;

      // Round-robin order with single-beat packets: 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("rr_order", 64'(grant_idx), 64'(i % N));
         chk("rr_data",  64'(out_data),  64'(32'h1000_0000 + 32'(i % N)));
         tick();
      end

      // Packet lock: ch1 sends three beats while ch0 and ch2 also request.
      in_valid = 4'b0111;
      in_last  = 4'b0101;
      for (int b = 0; b < 3; b++) begin
         in_last[1] = (b == 2);
         set_data(1, 32'hD000_0000 + 32'(b));
         settle();
         chk("lock_grant", 64'(grant_idx), 64'(1));
         chk("lock_data",  64'(out_data),  64'(32'hD000_0000 + 32'(b)));
         tick();
      end
      in_valid = 4'b0101;
      settle();
      chk("lock_next_grant", 64'(grant_idx), 64'(2));
      tick();

      // Backpressure: ch3 offered with out_ready low; ch0 appears a cycle later.
      in_valid  = 4'b1000;
      in_last   = 4'b1111;
      out_ready = 1'b0;
      set_data(3, 32'hA5A5_A5A5);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) in_valid[0] = 1'b1;
         settle();
         chk("bp_data",  64'(out_data),  64'(32'hA5A5_A5A5));
         chk("bp_grant", 64'(grant_idx), 64'(3));
         tick();
      end
      out_ready = 1'b1;
      settle();
      chk("bp_accept_ready", 64'(in_ready), 64'(4'b1000));
      tick();

      // Mid-packet gap on ch2 while ch0 waits.
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      set_data(2, 32'h2222_0001);
      settle();
      chk("gap_first_grant", 64'(grant_idx), 64'(2));
      tick();
      in_valid = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("gap_out_valid", 64'(out_valid),   64'(0));
         chk("gap_ch0_ready", 64'(in_ready[0]), 64'(0));
         chk("gap_locked",    64'(locked),      64'(1));
         tick();
      end
      in_valid   = 4'b0101;
      in_last[2] = 1'b1;
      set_data(2, 32'h2222_0002);
      settle();
      chk("gap_last_grant", 64'(grant_idx), 64'(2));
      chk("gap_last_data",  64'(out_data),  64'(32'h2222_0002));
      tick();
      in_valid = 4'b0000;
      settle();
      chk("gap_released", 64'(locked), 64'(0));
      tick();

      // Wrap: ch3 holds the priority, starts a packet, then reset hits mid-packet.
      in_valid = 4'b1000;
      in_last  = 4'b0000;
      settle();
      chk("wrap_grant", 64'(grant_idx), 64'(3));
      tick();
      rst      = 1'b1;
      in_valid = 4'b1001;
      in_last  = 4'b1111;
      settle();
      chk("midrst_locked", 64'(locked), 64'(0));
      tick();
      rst = 1'b0;
      settle();
      chk("post_rst_grant",  64'(grant_idx), 64'(0));
      chk("post_rst_locked", 64'(locked),    64'(0));
      tick();

      // Random traffic against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            in_last[i] = ($urandom_range(0, 2) == 0);
            set_data(i, $urandom);
         end
         settle();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
